// File: rtl/grf_wp_arb_if.sv
// Register-file write-port bus: pipeline writeback (port A), long-latency unit
// results (port B), hazard stall request, and the single GRF write port.
interface grf_wp_arb_if;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic [31:0] b_pc;
  logic        stall_req;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  modport master (
    output a_we, a_wa, a_wd, a_pc,
    output b_valid, b_wa, b_wd, b_pc,
    input  b_ready, stall_req,
    input  grf_we, grf_wa, grf_wd, grf_pc
  );

  modport slave (
    input  a_we, a_wa, a_wd, a_pc,
    input  b_valid, b_wa, b_wd, b_pc,
    output b_ready, stall_req,
    output grf_we, grf_wa, grf_wd, grf_pc
  );
endinterface

// File: rtl/grf_wp_arb.sv
// Register-file write-port arbiter: port A always wins, port B is served when
// A is idle, and a starved B forces a writeback stall after STARVE_LIM cycles.
module grf_wp_arb #(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic         clk,
  input  logic         rst,
  grf_wp_arb_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FORCE} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t      r_state, w_state_nx;
  logic [3:0]  r_blk_cnt, w_blk_cnt_nx, w_blk_inc;
  logic        r_stall;
  logic        r_grf_we;
  logic [4:0]  r_grf_wa;
  logic [31:0] r_grf_wd, r_grf_pc;
  logic        w_a_req, w_b_ready, w_blocked, w_b_wr;

  assign w_a_req   = bus.a_we && (bus.a_wa != '0);
  assign w_b_ready = bus.b_valid && (!w_a_req || (bus.b_wa == '0));
  assign w_blocked = bus.b_valid && !w_b_ready;
  // Register 0 results are accepted and dropped, so only nonzero targets write.
  assign w_b_wr    = w_b_ready && (bus.b_wa != '0);
  assign w_blk_inc = (r_blk_cnt == 4'hF) ? 4'hF : r_blk_cnt + 4'd1;

  always_comb begin
    w_state_nx   = r_state;
    w_blk_cnt_nx = r_blk_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_blocked) begin
          w_blk_cnt_nx = 4'd1;
          w_state_nx   = (4'd1 >= LIM) ? S_FORCE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_blocked) begin
          w_state_nx   = S_IDLE;
          w_blk_cnt_nx = '0;
        end else begin
          w_blk_cnt_nx = w_blk_inc;
          w_state_nx   = (w_blk_inc < LIM) ? S_WAIT : S_FORCE;
        end
      end
      S_FORCE: begin
        if (!w_blocked) begin
          w_state_nx   = S_IDLE;
          w_blk_cnt_nx = '0;
        end
      end
      default: begin
        w_state_nx   = S_IDLE;
        w_blk_cnt_nx = '0;
      end
    endcase
  end

  // Stall is registered from the next state so it tracks FORCE without glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_blk_cnt <= '0;
      r_stall   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_blk_cnt <= w_blk_cnt_nx;
      r_stall   <= (w_state_nx == S_FORCE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grf_we <= 1'b0;
      r_grf_wa <= '0;
      r_grf_wd <= '0;
      r_grf_pc <= '0;
    end else if (w_a_req) begin
      r_grf_we <= 1'b1;
      r_grf_wa <= bus.a_wa;
      r_grf_wd <= bus.a_wd;
      r_grf_pc <= bus.a_pc;
    end else if (w_b_wr) begin
      r_grf_we <= 1'b1;
      r_grf_wa <= bus.b_wa;
      r_grf_wd <= bus.b_wd;
      r_grf_pc <= bus.b_pc;
    end else begin
      r_grf_we <= 1'b0;
    end
  end

  assign bus.b_ready   = w_b_ready;
  assign bus.stall_req = r_stall;
  assign bus.grf_we    = r_grf_we;
  assign bus.grf_wa    = r_grf_wa;
  assign bus.grf_wd    = r_grf_wd;
  assign bus.grf_pc    = r_grf_pc;

endmodule

// File: tb/tb_grf_wp_arb.sv
// Directed bench for grf_wp_arb: STARVE_LIM=4 main instance plus a
// STARVE_LIM=1 instance for the single-cycle starvation path.
module tb_grf_wp_arb;

  logic clk;
  logic rst;
  int unsigned n_chk;
  int unsigned n_pass;

  grf_wp_arb_if bus ();
  grf_wp_arb_if bus1 ();

  grf_wp_arb #(.STARVE_LIM(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  grf_wp_arb #(.STARVE_LIM(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_a(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    bus.a_we = we;
    bus.a_wa = wa;
    bus.a_wd = wd;
    bus.a_pc = pc;
  endtask

  task automatic set_b(input logic v, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    bus.b_valid = v;
    bus.b_wa    = wa;
    bus.b_wd    = wd;
    bus.b_pc    = pc;
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    set_a(1'b0, 5'd0, 32'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0, 32'd0);
    bus1.a_we = 1'b0; bus1.a_wa = '0; bus1.a_wd = '0; bus1.a_pc = '0;
    bus1.b_valid = 1'b0; bus1.b_wa = '0; bus1.b_wd = '0; bus1.b_pc = '0;
    tick();
    tick();
    check("rst_we",    32'(bus.grf_we),    32'd0);
    check("rst_wa",    32'(bus.grf_wa),    32'd0);
    check("rst_wd",    bus.grf_wd,         32'd0);
    check("rst_pc",    bus.grf_pc,         32'd0);
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    check("rst_rdy",   32'(bus.b_ready),   32'd0);
    rst = 1'b0;
    tick();

    // Port A write, one cycle latency
    set_a(1'b1, 5'd5, 32'h1234, 32'h100);
    #1 check("a_rdy0", 32'(bus.b_ready), 32'd0);
    tick();
    check("a_we", 32'(bus.grf_we), 32'd1);
    check("a_wa", 32'(bus.grf_wa), 32'd5);
    check("a_wd", bus.grf_wd,      32'h1234);
    check("a_pc", bus.grf_pc,      32'h100);
    check("a_stall", 32'(bus.stall_req), 32'd0);
    set_a(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    check("idle_we",   32'(bus.grf_we), 32'd0);
    check("idle_hold", 32'(bus.grf_wa), 32'd5);

    // Port B alone is accepted immediately
    set_b(1'b1, 5'd8, 32'hCAFE, 32'h200);
    #1 check("b_rdy", 32'(bus.b_ready), 32'd1);
    tick();
    check("b_we", 32'(bus.grf_we), 32'd1);
    check("b_wa", 32'(bus.grf_wa), 32'd8);
    check("b_wd", bus.grf_wd,      32'hCAFE);
    check("b_pc", bus.grf_pc,      32'h200);
    set_b(1'b0, 5'd0, 32'd0, 32'd0);

    // Starvation: six blocked cycles, stall after the fourth blocked edge
    set_b(1'b1, 5'd3, 32'hBEEF, 32'h300);
    for (int i = 1; i <= 6; i++) begin
      set_a(1'b1, 5'd7, 32'h7000 + 32'(i), 32'h400);
      #1 check("st_rdy", 32'(bus.b_ready), 32'd0);
      tick();
      check("st_awa",   32'(bus.grf_wa),    32'd7);
      check("st_awd",   bus.grf_wd,         32'h7000 + 32'(i));
      check("st_stall", 32'(bus.stall_req), (i >= 4) ? 32'd1 : 32'd0);
    end
    set_a(1'b0, 5'd0, 32'd0, 32'd0);
    #1 check("st_rdy1", 32'(bus.b_ready), 32'd1);
    tick();
    check("st_bwe",   32'(bus.grf_we),    32'd1);
    check("st_bwa",   32'(bus.grf_wa),    32'd3);
    check("st_bwd",   bus.grf_wd,         32'hBEEF);
    check("st_stal0", 32'(bus.stall_req), 32'd0);
    set_b(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    check("st_nodup", 32'(bus.grf_we), 32'd0);

    // Register 0 handling
    set_a(1'b1, 5'd0, 32'hDEAD, 32'h500);
    set_b(1'b1, 5'd9, 32'h99, 32'h600);
    #1 check("z_rdy", 32'(bus.b_ready), 32'd1);
    tick();
    check("z_we", 32'(bus.grf_we), 32'd1);
    check("z_wa", 32'(bus.grf_wa), 32'd9);
    check("z_wd", bus.grf_wd,      32'h99);
    set_a(1'b0, 5'd0, 32'd0, 32'd0);
    set_b(1'b1, 5'd0, 32'h77, 32'h700);
    #1 check("z0_rdy", 32'(bus.b_ready), 32'd1);
    tick();
    check("z0_we",   32'(bus.grf_we), 32'd0);
    check("z0_hold", 32'(bus.grf_wa), 32'd9);
    set_a(1'b1, 5'd4, 32'h44, 32'h800);
    #1 check("z0a_rdy", 32'(bus.b_ready), 32'd1);
    tick();
    check("z0a_wa", 32'(bus.grf_wa), 32'd4);
    check("z0a_st", 32'(bus.stall_req), 32'd0);
    set_a(1'b0, 5'd0, 32'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0, 32'd0);
    tick();

    // b_valid drops mid-WAIT: no write, counter restarts
    set_b(1'b1, 5'd6, 32'h66, 32'h900);
    set_a(1'b1, 5'd2, 32'h22, 32'hA00);
    tick();
    tick();
    set_b(1'b0, 5'd6, 32'h66, 32'h900);
    set_a(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    check("drop_we", 32'(bus.grf_we),    32'd0);
    check("drop_st", 32'(bus.stall_req), 32'd0);
    set_b(1'b1, 5'd6, 32'h66, 32'h900);
    set_a(1'b1, 5'd2, 32'h22, 32'hA00);
    tick();
    tick();
    tick();
    check("drop_st3", 32'(bus.stall_req), 32'd0);
    tick();
    check("drop_st4", 32'(bus.stall_req), 32'd1);

    // Asynchronous reset while in FORCE
    #2 rst = 1'b1;
    #1;
    check("ar_st", 32'(bus.stall_req), 32'd0);
    check("ar_we", 32'(bus.grf_we),    32'd0);
    check("ar_wa", 32'(bus.grf_wa),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("ar_cnt3", 32'(bus.stall_req), 32'd0);
    tick();
    check("ar_cnt4", 32'(bus.stall_req), 32'd1);
    set_a(1'b0, 5'd0, 32'd0, 32'd0);
    set_b(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    check("ar_drop", 32'(bus.grf_we),    32'd0);
    check("ar_idle", 32'(bus.stall_req), 32'd0);

    // STARVE_LIM=1: one blocked cycle goes straight to FORCE
    bus1.b_valid = 1'b1; bus1.b_wa = 5'd2; bus1.b_wd = 32'h2222; bus1.b_pc = 32'hB00;
    bus1.a_we = 1'b1; bus1.a_wa = 5'd1; bus1.a_wd = 32'h1111; bus1.a_pc = 32'hC00;
    #1 check("l1_rdy0", 32'(bus1.b_ready), 32'd0);
    tick();
    check("l1_st",  32'(bus1.stall_req), 32'd1);
    check("l1_awa", 32'(bus1.grf_wa),    32'd1);
    bus1.a_we = 1'b0;
    #1 check("l1_rdy1", 32'(bus1.b_ready), 32'd1);
    tick();
    check("l1_st0", 32'(bus1.stall_req), 32'd0);
    check("l1_bwa", 32'(bus1.grf_wa),    32'd2);
    check("l1_bwd", bus1.grf_wd,         32'h2222);
    bus1.b_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/grf_wp_arb.md
GRF_WP_ARB -- requirements
Module: grf_wp_arb

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 4, meaning consecutive blocked cycles of port B before a stall is forced (legal range 1..15).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port a_we  in  1  pipeline writeback request (port A, cannot be back-pressured).
REQ-005 SHALL have port a_wa  in  5  port A destination register.
REQ-006 SHALL have port a_wd  in  32  port A write data.
REQ-007 SHALL have port a_pc  in  32  port A instruction PC.
REQ-008 SHALL have port b_valid  in  1  long-latency unit result valid (port B).
REQ-009 SHALL have port b_ready  out  1  port B accepted this cycle.
REQ-010 SHALL have ports b_wa  in  5, b_wd  in  32, b_pc  in  32  port B address, data and PC.
REQ-011 SHALL have port stall_req  out  1  request to the hazard unit to bubble the writeback stage.
REQ-012 SHALL have ports grf_we  out  1, grf_wa  out  5, grf_wd  out  32, grf_pc  out  32  the single register-file write port.

Function
REQ-013 SHALL define a_req = a_we && (a_wa != 0); a_we with a_wa == 0 is a no-op and never blocks port B.
REQ-014 SHALL drive b_ready combinationally: b_ready = b_valid && (!a_req || b_wa == 0).
REQ-015 SHALL accept port B with b_wa == 0 on any cycle b_valid is high and discard it, issuing no write.
REQ-016 SHALL give port A absolute priority; a_req is always forwarded, in every state.
REQ-017 SHALL register the write port: on the edge after a_req, grf_we=1 and grf_wa/wd/pc = a_*; else, on the edge after a B handshake with b_wa != 0, grf_we=1 and grf_* = b_*; else grf_we=0 and grf_wa/wd/pc hold their previous values.
REQ-018 SHALL have fixed write latency of exactly 1 cycle from grant to grf_we.
REQ-019 SHALL implement FSM states IDLE, WAIT, FORCE.
REQ-020 IDLE: b_valid && !b_ready -> WAIT with blk_cnt=1; otherwise stay in IDLE.
REQ-021 WAIT: B handshake or !b_valid -> IDLE, blk_cnt=0; blocked, blk_cnt+1 < STARVE_LIM -> stay, blk_cnt+1; blocked, blk_cnt+1 >= STARVE_LIM -> FORCE.
REQ-022 FORCE: B handshake or !b_valid -> IDLE, blk_cnt=0; otherwise stay (in-flight A writes still win).
REQ-023 SHALL drive stall_req=1 exactly while the state is FORCE (registered, glitch-free).
REQ-024 SHALL keep blk_cnt 4 bits wide and saturating, never wrapping.
REQ-025 With STARVE_LIM=1, a single blocked cycle SHALL move IDLE directly to FORCE.
REQ-026 SHALL tolerate b_valid dropping without a handshake, returning to IDLE with no write issued.
REQ-027 SHALL never assert grf_we for two sources in one cycle, and SHALL never drop or duplicate an accepted B result.

Reset
REQ-028 While rst is high, SHALL force state IDLE, blk_cnt=0, stall_req=0, grf_we=0, grf_wa=0, grf_wd=0 and grf_pc=0, asynchronously.
REQ-029 rst asserted mid-WAIT or mid-FORCE SHALL abandon the pending B request without a write; b_ready stays combinational per REQ-014.

Verification
REQ-030 a_we=1, a_wa=5, a_wd=0x1234 and b_valid=0 -> next cycle grf_we=1, grf_wa=5, grf_wd=0x1234; stall_req stays 0.
REQ-031 b_valid=1, b_wa=8, b_wd=0xCAFE and a_we=0 -> b_ready=1 the same cycle; next cycle grf_wa=8, grf_wd=0xCAFE.
REQ-032 STARVE_LIM=4, b_valid=1 (b_wa=3) and a_req for 6 cycles -> stall_req rises after the 4th blocked edge; drop a_we -> b_ready=1, the write issues, stall_req falls on the following edge.
REQ-033 a_we=1 with a_wa=0, plus b_valid with b_wa=9 -> b_ready=1; only the $9 write appears; b_wa=0 alone -> b_ready=1 and grf_we stays 0.
REQ-034 assert rst asynchronously while in FORCE -> stall_req=0 and grf_we=0 immediately; after release the state is IDLE and blk_cnt restarts from 0.
